// File: rtl/serial_io_access_sequencer.sv
// ----------------------------------------------------------------------------
// serial_io_access_sequencer
//
// Purpose:
//   Runs HPS-bridge byte accesses to four 16550 UARTs mapped at 0x0200-0x023F.
//   A request is taken only in IDLE. The target UART is decoded and the
//   transaction fields are latched. The module then runs a bus cycle in four
//   phases: setup, strobe, hold and a one-cycle acknowledge. Setup, strobe and
//   hold lengths are set by parameters. An address that decodes to no UART
//   skips the bus cycle and acknowledges with the error flag set.
//
// Ports:
//   i_clock              system clock, rising edge
//   i_reset_h            synchronous active-high reset
//   i_req_h              request, held until o_ack_h is seen
//   i_address[15:0]      bridge address
//   i_ioselect_h         address lies in the IO window
//   i_byteselect_l       0 = even byte lane (required for UART access)
//   i_write_h            1 = write, 0 = read
//   i_write_data[7:0]    write byte
//   o_ack_h              one-cycle completion pulse
//   o_error_h            with o_ack_h: access decoded to no UART
//   o_read_data[7:0]     last byte read, held until the next read completes
//   o_port_enable[3:0]   one-hot UART enable: RS232, GPS, Bluetooth, WiFi
//   o_uart_addr[2:0]     16550 register select (address bits 3:1)
//   o_uart_rd_l          read strobe, active low
//   o_uart_wr_l          write strobe, active low
//   o_uart_data_out[7:0] byte driven to the UART bus
//   o_uart_data_out_en_h drive enable for o_uart_data_out (writes only)
//   i_uart_data_in[7:0]  byte returned from the UART bus
// ----------------------------------------------------------------------------
module serial_io_access_sequencer #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1,
  parameter int CNT_W         = 4
) (
  input  logic        i_clock,
  input  logic        i_reset_h,
  input  logic        i_req_h,
  input  logic [15:0] i_address,
  input  logic        i_ioselect_h,
  input  logic        i_byteselect_l,
  input  logic        i_write_h,
  input  logic [7:0]  i_write_data,
  output logic        o_ack_h,
  output logic        o_error_h,
  output logic [7:0]  o_read_data,
  output logic [3:0]  o_port_enable,
  output logic [2:0]  o_uart_addr,
  output logic        o_uart_rd_l,
  output logic        o_uart_wr_l,
  output logic [7:0]  o_uart_data_out,
  output logic        o_uart_data_out_en_h,
  input  logic [7:0]  i_uart_data_in
);

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_write;

  logic             w_valid;
  logic [3:0]       w_port_onehot;
  logic             w_unused_addr_bit;

  // Decode the UART window: 0x0200-0x023F, on the even byte lane only.
  assign w_valid = i_ioselect_h & ~i_byteselect_l & (i_address[15:6] == 10'h008);
  assign w_port_onehot = 4'b0001 << i_address[5:4];
  // Address bit 0 selects a byte within the bridge word and has no role here.
  assign w_unused_addr_bit = i_address[0];

  // Sequencer FSM; every output is a register written alongside the state.
  always_ff @(posedge i_clock) begin
    if (i_reset_h) begin
      r_state              <= ST_IDLE;
      r_cnt                <= '0;
      r_write              <= 1'b0;
      o_ack_h              <= 1'b0;
      o_error_h            <= 1'b0;
      o_read_data          <= 8'h00;
      o_port_enable        <= 4'b0000;
      o_uart_addr          <= 3'd0;
      o_uart_rd_l          <= 1'b1;
      o_uart_wr_l          <= 1'b1;
      o_uart_data_out      <= 8'h00;
      o_uart_data_out_en_h <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_ack_h   <= 1'b0;
          o_error_h <= 1'b0;
          if (i_req_h && w_valid) begin
            // Latch everything now; later input changes must not matter.
            r_state              <= ST_SETUP;
            r_cnt                <= SETUP_LOAD;
            r_write              <= i_write_h;
            o_port_enable        <= w_port_onehot;
            o_uart_addr          <= i_address[3:1];
            o_uart_data_out      <= i_write_data;
            o_uart_data_out_en_h <= i_write_h;
          end else if (i_req_h) begin
            // No UART is selected: skip the bus cycle and report the error.
            r_state   <= ST_DONE;
            o_ack_h   <= 1'b1;
            o_error_h <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (r_cnt == '0) begin
            r_state     <= ST_STROBE;
            r_cnt       <= STROBE_LOAD;
            o_uart_rd_l <= r_write;
            o_uart_wr_l <= ~r_write;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          if (r_cnt == '0) begin
            r_state     <= ST_HOLD;
            r_cnt       <= HOLD_LOAD;
            o_uart_rd_l <= 1'b1;
            o_uart_wr_l <= 1'b1;
            // Sample read data on the rising strobe edge.
            if (!r_write) begin
              o_read_data <= i_uart_data_in;
            end else begin
              o_read_data <= o_read_data;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_state              <= ST_DONE;
            o_ack_h              <= 1'b1;
            o_error_h            <= 1'b0;
            o_port_enable        <= 4'b0000;
            o_uart_data_out_en_h <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          o_ack_h   <= 1'b0;
          o_error_h <= 1'b0;
        end
        default: begin
          r_state              <= ST_IDLE;
          o_ack_h              <= 1'b0;
          o_error_h            <= 1'b0;
          o_port_enable        <= 4'b0000;
          o_uart_rd_l          <= 1'b1;
          o_uart_wr_l          <= 1'b1;
          o_uart_data_out_en_h <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_io_access_sequencer.sv
// ----------------------------------------------------------------------------
// tb_serial_io_access_sequencer
//
// Self-checking bench. A timeline model predicts every output from the number
// of cycles since a request was accepted. It uses only the transaction's
// decoded fields and the phase lengths. A negedge process compares all DUT
// outputs against it every cycle. Directed scenarios add literal expectations
// that pin the model itself.
// ----------------------------------------------------------------------------
module tb_serial_io_access_sequencer;

  localparam int S = 2;
  localparam int T = 4;
  localparam int H = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [15:0] addr;
  logic        iosel;
  logic        bsel_l;
  logic        wr;
  logic [7:0]  wdata;
  logic [7:0]  din;
  logic        ack, err, rd_l, wr_l, oe;
  logic [7:0]  rdata, dout;
  logic [3:0]  pe;
  logic [2:0]  ua;

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  serial_io_access_sequencer #(
    .SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H), .CNT_W(4)
  ) dut (
    .i_clock(clk), .i_reset_h(rst), .i_req_h(req), .i_address(addr),
    .i_ioselect_h(iosel), .i_byteselect_l(bsel_l), .i_write_h(wr),
    .i_write_data(wdata), .o_ack_h(ack), .o_error_h(err), .o_read_data(rdata),
    .o_port_enable(pe), .o_uart_addr(ua), .o_uart_rd_l(rd_l), .o_uart_wr_l(wr_l),
    .o_uart_data_out(dout), .o_uart_data_out_en_h(oe), .i_uart_data_in(din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- timeline model ----------------
  logic       m_busy = 1'b0;
  int         m_k = 0;
  logic       m_valid, m_wr;
  int         m_port;
  logic [2:0] m_reg;
  logic [7:0] m_wd;
  logic [7:0] m_rd = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_rd   <= 8'h00;
    end else if (!m_busy) begin
      if (req) begin
        m_busy  <= 1'b1;
        m_k     <= 1;
        m_valid <= iosel && !bsel_l && addr >= 16'h0200 && addr < 16'h0240;
        m_port  <= (int'(addr) - 32'h200) / 16;
        m_reg   <= 3'((int'(addr) % 16) / 2);
        m_wr    <= wr;
        m_wd    <= wdata;
      end
    end else begin
      if (m_valid && !m_wr && m_k == S + T) m_rd <= din;
      if (m_k == (m_valid ? S + T + H + 1 : 1)) m_busy <= 1'b0;
      else m_k <= m_k + 1;
    end
  end

  // Compare every DUT output against the model each cycle.
  always @(negedge clk) begin
    logic [3:0] e_pe;
    logic e_rd, e_wr, e_oe, e_ack, e_err;
    if (chk_en) begin
      e_pe = 4'b0000; e_rd = 1'b1; e_wr = 1'b1; e_oe = 1'b0; e_ack = 1'b0; e_err = 1'b0;
      if (m_busy) begin
        if (!m_valid) begin
          e_ack = 1'b1; e_err = 1'b1;
        end else if (m_k <= S + T + H) begin
          e_pe = 4'b0001 << m_port;
          e_oe = m_wr;
          if (m_k > S && m_k <= S + T) begin
            if (m_wr) e_wr = 1'b0; else e_rd = 1'b0;
          end
        end else begin
          e_ack = 1'b1;
        end
      end
      chk("m_port_enable", 32'(pe), 32'(e_pe));
      chk("m_rd_l", 32'(rd_l), 32'(e_rd));
      chk("m_wr_l", 32'(wr_l), 32'(e_wr));
      chk("m_data_out_en", 32'(oe), 32'(e_oe));
      chk("m_ack", 32'(ack), 32'(e_ack));
      if (e_ack) chk("m_error", 32'(err), 32'(e_err));
      chk("m_read_data", 32'(rdata), 32'(m_rd));
      if (e_pe != 4'b0000) chk("m_uart_addr", 32'(ua), 32'(m_reg));
      if (e_oe) chk("m_data_out", 32'(dout), 32'(m_wd));
    end
  end

  // Issue one request and follow it until o_ack_h, gathering a summary.
  task automatic issue(input logic [15:0] a, input logic ios, input logic bs,
                       input logic w, input logic [7:0] wd, input logic [7:0] di,
                       input logic scramble,
                       output int n_ack, output int n_rd, output int n_wr, output int n_oe,
                       output logic [3:0] pe1, output logic [2:0] ua1, output logic err_ack);
    addr = a; iosel = ios; bsel_l = bs; wr = w; wdata = wd; din = di; req = 1'b1;
    n_ack = 0; n_rd = 0; n_wr = 0; n_oe = 0; pe1 = 4'b0000; ua1 = 3'd0; err_ack = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!rd_l) n_rd++;
      if (!wr_l) n_wr++;
      if (oe) n_oe++;
      if (n == 1) begin pe1 = pe; ua1 = ua; end
      if (scramble && n == 3) begin
        addr = 16'($urandom); wr = ~wr; wdata = 8'($urandom);
        iosel = 1'($urandom); bsel_l = 1'($urandom);
      end
      if (ack) begin n_ack = n; err_ack = err; break; end
    end
    chk("ack_seen", 32'(n_ack != 0), 32'd1);
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  initial begin
    int na, nr, nw, no, cnt;
    logic [3:0] p1;
    logic [2:0] u1;
    logic e1, found;
    rst = 1'b1; req = 1'b0; addr = 16'h0000; iosel = 1'b0; bsel_l = 1'b1;
    wr = 1'b0; wdata = 8'h00; din = 8'h00;
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_pe", 32'(pe), 32'd0);
    chk("reset_strobes", 32'({rd_l, wr_l}), 32'd3);
    chk("reset_rdata", 32'(rdata), 32'd0);
    @(posedge clk);

    // 1: reset while a write strobe is active
    #1 addr = 16'h0204; iosel = 1'b1; bsel_l = 1'b0; wr = 1'b1; wdata = 8'h99; req = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!wr_l) begin found = 1'b1; break; end
    end
    chk("t1_strobe_reached", 32'(found), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t1_wr_l", 32'(wr_l), 32'd1);
    chk("t1_pe", 32'(pe), 32'd0);
    chk("t1_oe", 32'(oe), 32'd0);
    rst = 1'b0; req = 1'b0;
    cnt = 0;
    repeat (12) begin @(negedge clk); if (ack) cnt++; end
    chk("t1_no_ack", 32'(cnt), 32'd0);
    @(posedge clk);
    #1;

    // 2: read GPS register 2
    issue(16'h0214, 1'b1, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, na, nr, nw, no, p1, u1, e1);
    chk("t2_pe", 32'(p1), 32'b0010);
    chk("t2_ua", 32'(u1), 32'd2);
    chk("t2_rd_cycles", 32'(nr), 32'd4);
    chk("t2_wr_cycles", 32'(nw), 32'd0);
    chk("t2_ack_cycle", 32'(na), 32'd8);
    chk("t2_err", 32'(e1), 32'd0);
    chk("t2_rdata", 32'(rdata), 32'hA5);

    // 3: write WiFi register 7
    issue(16'h023E, 1'b1, 1'b0, 1'b1, 8'h3C, 8'h00, 1'b0, na, nr, nw, no, p1, u1, e1);
    chk("t3_pe", 32'(p1), 32'b1000);
    chk("t3_ua", 32'(u1), 32'd7);
    chk("t3_oe_cycles", 32'(no), 32'd7);
    chk("t3_wr_cycles", 32'(nw), 32'd4);
    chk("t3_ack_cycle", 32'(na), 32'd8);
    chk("t3_rdata_kept", 32'(rdata), 32'hA5);

    // 4: three error decodes
    issue(16'h0240, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, na, nr, nw, no, p1, u1, e1);
    chk("t4a_ack_cycle", 32'(na), 32'd1);
    chk("t4a_err", 32'(e1), 32'd1);
    chk("t4a_pe", 32'(p1), 32'd0);
    issue(16'h0210, 1'b1, 1'b1, 1'b1, 8'h55, 8'h00, 1'b0, na, nr, nw, no, p1, u1, e1);
    chk("t4b_ack_cycle", 32'(na), 32'd1);
    chk("t4b_err", 32'(e1), 32'd1);
    chk("t4b_strobes", 32'(nr + nw + no), 32'd0);
    issue(16'h0220, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, na, nr, nw, no, p1, u1, e1);
    chk("t4c_ack_cycle", 32'(na), 32'd1);
    chk("t4c_err", 32'(e1), 32'd1);

    // 5: back-to-back to all four ports with inputs scrambled mid-flight
    issue(16'h0200, 1'b1, 1'b0, 1'b1, 8'h11, 8'h00, 1'b1, na, nr, nw, no, p1, u1, e1);
    chk("t5a_pe", 32'(p1), 32'b0001);
    chk("t5a_wr_cycles", 32'(nw), 32'd4);
    issue(16'h0216, 1'b1, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b1, na, nr, nw, no, p1, u1, e1);
    chk("t5b_pe", 32'(p1), 32'b0010);
    chk("t5b_ua", 32'(u1), 32'd3);
    chk("t5b_rdata", 32'(rdata), 32'h5A);
    issue(16'h022A, 1'b1, 1'b0, 1'b1, 8'h77, 8'hEE, 1'b1, na, nr, nw, no, p1, u1, e1);
    chk("t5c_pe", 32'(p1), 32'b0100);
    chk("t5c_ua", 32'(u1), 32'd5);
    chk("t5c_rdata_kept", 32'(rdata), 32'h5A);
    issue(16'h0238, 1'b1, 1'b0, 1'b0, 8'h00, 8'hC3, 1'b1, na, nr, nw, no, p1, u1, e1);
    chk("t5d_pe", 32'(p1), 32'b1000);
    chk("t5d_ack_cycle", 32'(na), 32'd8);
    chk("t5d_rdata", 32'(rdata), 32'hC3);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
